// File: rtl/eager_fanout_fork.sv
// eager_fanout_fork
//   Eager fork that broadcasts one ready/valid stream to NUM_OUT consumers.
//   Each active branch (cfg_en & cfg_sel) takes the token independently. A
//   per-branch done flag records which branches already took it. The input
//   token completes once every active branch is done or ready this cycle.
// Ports
//   clk, rst_n            clock, async active-low reset
//   flush                 sync clear of done flags and counters
//   cfg_en, cfg_sel       static branch enable / select
//   in_data/valid/ready   upstream ready/valid stream
//   out_data              broadcast token (equal to in_data)
//   out_valid/out_ready   per-branch handshake
//   accept_cnt            per-branch saturating handshake counts, branch i at [i*CNT_W +: CNT_W]
//   drop_cnt              saturating count of tokens consumed with no active branch
module eager_fanout_fork #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NUM_OUT = 9,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_OUT-1:0]       cfg_en,
  input  logic [NUM_OUT-1:0]       cfg_sel,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [NUM_OUT*CNT_W-1:0] accept_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_OUT-1:0] active;
  logic [NUM_OUT-1:0] hs;
  logic [NUM_OUT-1:0] done_q, done_d;
  logic               fire;
  logic [CNT_W-1:0]   acc_q [NUM_OUT];
  logic [CNT_W-1:0]   acc_d [NUM_OUT];
  logic [CNT_W-1:0]   drop_q, drop_d;

  assign active   = cfg_en & cfg_sel;
  assign out_data = in_data;

  // Handshake outputs are gated by rst_n so nothing moves while reset is held.
  assign out_valid = {NUM_OUT{in_valid & rst_n}} & active & ~done_q;
  assign in_ready  = rst_n & (&(~active | done_q | out_ready));

  assign hs   = out_valid & out_ready;
  assign fire = in_valid & in_ready;

  // Done flags: cleared when the token completes, otherwise accumulate handshakes.
  always_comb begin
    done_d = done_q | hs;
    if (flush || fire) begin
      done_d = '0;
    end
  end

  // Saturating counters; a flush cycle clears them and counts nothing.
  always_comb begin
    for (int i = 0; i < int'(NUM_OUT); i++) begin
      acc_d[i] = acc_q[i];
      if (flush) begin
        acc_d[i] = '0;
      end else if (hs[i] && (acc_q[i] != CNT_MAX)) begin
        acc_d[i] = acc_q[i] + CNT_W'(1);
      end
    end
    drop_d = drop_q;
    if (flush) begin
      drop_d = '0;
    end else if (fire && !(|active) && (drop_q != CNT_MAX)) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
      drop_q <= '0;
      for (int i = 0; i < int'(NUM_OUT); i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      done_q <= done_d;
      drop_q <= drop_d;
      for (int i = 0; i < int'(NUM_OUT); i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  // Pack per-branch counters onto the flat output bus.
  for (genvar g = 0; g < int'(NUM_OUT); g++) begin : g_pack
    assign accept_cnt[g*CNT_W +: CNT_W] = acc_q[g];
  end

  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_eager_fanout_fork.sv
// Directed bench for eager_fanout_fork: a default-size instance plus a
// CNT_W=4 instance sharing the same stimulus for the saturation case.
module tb_eager_fanout_fork;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned NUM_OUT = 9;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CNT_WS  = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush;
  logic [NUM_OUT-1:0]       cfg_en, cfg_sel;
  logic [DATA_W-1:0]        in_data;
  logic                     in_valid;
  logic [NUM_OUT-1:0]       out_ready;

  logic                     in_ready_b, in_ready_s;
  logic [DATA_W-1:0]        out_data_b, out_data_s;
  logic [NUM_OUT-1:0]       out_valid_b, out_valid_s;
  logic [NUM_OUT*CNT_W-1:0] acc_b;
  logic [NUM_OUT*CNT_WS-1:0] acc_s;
  logic [CNT_W-1:0]         drop_b;
  logic [CNT_WS-1:0]        drop_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  eager_fanout_fork #(.DATA_W(DATA_W), .NUM_OUT(NUM_OUT), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cfg_en(cfg_en), .cfg_sel(cfg_sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .accept_cnt(acc_b), .drop_cnt(drop_b)
  );

  eager_fanout_fork #(.DATA_W(DATA_W), .NUM_OUT(NUM_OUT), .CNT_W(CNT_WS)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cfg_en(cfg_en), .cfg_sel(cfg_sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_s),
    .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .accept_cnt(acc_s), .drop_cnt(drop_s)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] accb(input int i);
    return 64'(acc_b[i*CNT_W +: CNT_W]);
  endfunction

  function automatic logic [63:0] accs(input int i);
    return 64'(acc_s[i*CNT_WS +: CNT_WS]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    in_valid  = 1'b0;
    out_ready = '0;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    cfg_en    = 9'h1FF;
    cfg_sel   = 9'h1FF;
    in_data   = 16'h0000;
    in_valid  = 1'b1;
    out_ready = 9'h1FF;

    // Reset state: handshakes forced low, counters zero.
    #2;
    chk("rst_out_valid", 64'(out_valid_b), 64'h0);
    chk("rst_in_ready",  64'(in_ready_b),  64'h0);
    chk("rst_acc0",      accb(0),          64'h0);
    chk("rst_drop",      64'(drop_b),      64'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // 1) All active, all ready: fire every cycle.
    in_data = 16'h00A5;
    #1;
    chk("t1_in_ready",  64'(in_ready_b),  64'h1);
    chk("t1_out_valid", 64'(out_valid_b), 64'h1FF);
    chk("t1_out_data",  64'(out_data_b),  64'h00A5);
    tick(); tick(); tick();
    for (int i = 0; i < int'(NUM_OUT); i++) chk($sformatf("t1_acc%0d", i), accb(i), 64'd3);
    chk("t1_drop", 64'(drop_b), 64'h0);
    do_flush();
    chk("flush_acc0", accb(0), 64'h0);
    chk("flush_acc8", accb(8), 64'h0);

    // 2) Staggered ready.
    in_data   = 16'h1234;
    in_valid  = 1'b1;
    out_ready = 9'h001;
    #1;
    chk("t2_c0_out_valid", 64'(out_valid_b), 64'h1FF);
    chk("t2_c0_in_ready",  64'(in_ready_b),  64'h0);
    tick();
    chk("t2_c1_out_valid", 64'(out_valid_b), 64'h1FE);
    chk("t2_c1_in_ready",  64'(in_ready_b),  64'h0);
    chk("t2_c1_acc0",      accb(0),          64'd1);
    out_ready = 9'h1FE;
    #1;
    chk("t2_c1_in_ready_up", 64'(in_ready_b), 64'h1);
    tick();
    chk("t2_next_out_valid", 64'(out_valid_b), 64'h1FF);
    in_valid = 1'b0;
    for (int i = 0; i < int'(NUM_OUT); i++) chk($sformatf("t2_acc%0d", i), accb(i), 64'd1);
    do_flush();

    // 3) Only branches 0 and 2 active; branch 0 blocks until ready.
    cfg_en    = 9'h005;
    cfg_sel   = 9'h1FF;
    in_data   = 16'h0BEE;
    in_valid  = 1'b1;
    out_ready = 9'h004;
    #1;
    chk("t3_out_valid", 64'(out_valid_b), 64'h005);
    chk("t3_in_ready",  64'(in_ready_b),  64'h0);
    tick();
    chk("t3_out_valid_d2", 64'(out_valid_b), 64'h001);
    out_ready = 9'h005;
    #1;
    chk("t3_in_ready_up", 64'(in_ready_b), 64'h1);
    tick();
    in_valid = 1'b0;
    chk("t3_acc0", accb(0), 64'd1);
    chk("t3_acc1", accb(1), 64'd0);
    chk("t3_acc2", accb(2), 64'd1);
    chk("t3_acc8", accb(8), 64'd0);
    chk("t3_drop", 64'(drop_b), 64'd0);
    do_flush();

    // 4) No active branch: tokens dropped.
    cfg_en   = 9'h000;
    in_valid = 1'b1;
    in_data  = 16'h7777;
    #1;
    chk("t4_in_ready",  64'(in_ready_b),  64'h1);
    chk("t4_out_valid", 64'(out_valid_b), 64'h0);
    for (int k = 0; k < 5; k++) tick();
    in_valid = 1'b0;
    chk("t4_drop",       64'(drop_b), 64'd5);
    chk("t4_drop_small", 64'(drop_s), 64'd5);
    chk("t4_acc0",       accb(0),     64'd0);
    do_flush();

    // 5) Reset mid-token: token re-offered after release.
    cfg_en    = 9'h003;
    cfg_sel   = 9'h1FF;
    in_data   = 16'h5A5A;
    in_valid  = 1'b1;
    out_ready = 9'h001;
    tick();
    chk("t5_out_valid_mid", 64'(out_valid_b), 64'h002);
    chk("t5_acc0_mid",      accb(0),          64'd1);
    out_ready = 9'h000;
    rst_n     = 1'b0;
    #1;
    chk("t5_rst_out_valid", 64'(out_valid_b), 64'h0);
    chk("t5_rst_in_ready",  64'(in_ready_b),  64'h0);
    chk("t5_rst_acc0",      accb(0),          64'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("t5_rel_out_valid", 64'(out_valid_b), 64'h003);
    chk("t5_rel_in_ready",  64'(in_ready_b),  64'h0);
    out_ready = 9'h003;
    #1;
    chk("t5_rel_in_ready_up", 64'(in_ready_b), 64'h1);
    tick();
    in_valid = 1'b0;
    chk("t5_acc0", accb(0), 64'd1);
    chk("t5_acc1", accb(1), 64'd1);
    do_flush();

    // 6) Saturation on the narrow instance, then flush with a live fire.
    cfg_en    = 9'h001;
    cfg_sel   = 9'h001;
    in_data   = 16'h0F0F;
    in_valid  = 1'b1;
    out_ready = 9'h001;
    for (int k = 0; k < 20; k++) tick();
    chk("t6_acc0_small_sat", accs(0), 64'd15);
    chk("t6_acc0_big",       accb(0), 64'd20);
    flush = 1'b1;
    #1;
    chk("t6_flush_in_ready", 64'(in_ready_s), 64'h1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t6_flush_acc0_small", accs(0), 64'd0);
    chk("t6_flush_acc0_big",   accb(0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
